apb_bldc_commutator: RTL and testbench

APB_BLDC_COMMUTATOR -- requirements
Module: apb_bldc_commutator

---
 rtl/apb_bldc_commutator.sv | 184 ++++++++++++++++++
 tb/tb_apb_bldc_commutator.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bldc_commutator.sv
// APB-controlled six-step BLDC commutator: hall decode, edge-aligned PWM on the
// high side, sticky invalid-hall fault, and a sector-change counter.
module apb_bldc_commutator #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int PWM_W      = 10,
  parameter int PERIOD_RST = 1002
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [2:0]        hall_values,
  output logic [5:0]        phase_enable,
  output logic              fault_irq,
  output logic [1:0]        dbg_state
);

  // APB handshake: a transfer is accepted with psel=1/penable=0, then the
  // master holds psel, penable, paddr, pwrite and pwdata until pready=1;
  // pready is high for exactly one cycle and writes commit at its end.
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} apb_state_e;

  apb_state_e       state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [PWM_W-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [PWM_W-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [31:0]      comm_q, comm_d;
  logic             fault_q, fault_d;
  logic [2:0]       hall_s1_q, hall_s2_q;
  logic [2:0]       prev_sector_q;
  logic [5:0]       pe_q, pe_d;

  logic       en, dir, brake, running, access, err, wr_ok, wrap, pwm_on;
  logic       sel_ctrl, sel_status, sel_period, sel_duty, sel_fclr, sel_comm, mapped;
  logic [2:0] sector, hi, lo;
  logic [DATA_W-1:0] rdata;

  assign en      = ctrl_q[0];
  assign dir     = ctrl_q[1];
  assign brake   = ctrl_q[2];
  assign running = en & ~fault_q & ~brake;
  assign access  = (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psel && !penable) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_ctrl   = (paddr == ADDR_W'('h00));
  assign sel_status = (paddr == ADDR_W'('h04));
  assign sel_period = (paddr == ADDR_W'('h08));
  assign sel_duty   = (paddr == ADDR_W'('h0C));
  assign sel_fclr   = (paddr == ADDR_W'('h10));
  assign sel_comm   = (paddr == ADDR_W'('h14));
  assign mapped     = sel_ctrl | sel_status | sel_period | sel_duty | sel_fclr | sel_comm;

  assign err   = ~mapped | (pwrite & (sel_status | sel_comm)) | (~pwrite & sel_fclr);
  assign wr_ok = access & pwrite & ~err;

  always_comb begin
    rdata = '0;
    if (sel_ctrl)   rdata = DATA_W'(ctrl_q);
    if (sel_status) rdata = DATA_W'({running, fault_q, sector, hall_s2_q});
    if (sel_period) rdata = DATA_W'(period_sh_q);
    if (sel_duty)   rdata = DATA_W'(duty_sh_q);
    if (sel_comm)   rdata = DATA_W'(comm_q);
  end

  assign pready    = access;
  assign pslverr   = access & err;
  assign prdata    = (access && !pwrite && !err) ? rdata : '0;
  assign fault_irq = fault_q;
  assign dbg_state = state_q;
  assign phase_enable = pe_q;

  always_comb begin
    case (hall_s2_q)
      3'b101:  sector = 3'd0;
      3'b100:  sector = 3'd1;
      3'b110:  sector = 3'd2;
      3'b010:  sector = 3'd3;
      3'b011:  sector = 3'd4;
      3'b001:  sector = 3'd5;
      default: sector = 3'd7;
    endcase
  end

  // Counter wraps after reaching PERIOD; PERIOD=0 keeps it pinned at zero.
  assign wrap   = (cnt_q >= period_act_q);
  assign cnt_d  = wrap ? '0 : cnt_q + 1'b1;
  assign pwm_on = (cnt_q < duty_act_q);

  always_comb begin
    ctrl_d       = ctrl_q;
    period_sh_d  = period_sh_q;
    duty_sh_d    = duty_sh_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    if (wr_ok && sel_ctrl)   ctrl_d      = 3'(pwdata);
    if (wr_ok && sel_period) period_sh_d = PWM_W'(pwdata);
    if (wr_ok && sel_duty)   duty_sh_d   = PWM_W'(pwdata);
    if (wrap || !en) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    fault_d = fault_q;
    if (wr_ok && sel_fclr && pwdata[0]) fault_d = 1'b0;
    if (en && sector == 3'd7)          fault_d = 1'b1;
  end

  always_comb begin
    comm_d = comm_q;
    if (sector != 3'd7 && prev_sector_q != 3'd7 && sector != prev_sector_q)
      comm_d = comm_q + 32'd1;
  end

  // One-hot phase masks {A,B,C}; CCW drives the same pairs with roles swapped.
  always_comb begin
    hi = 3'b000;
    lo = 3'b000;
    case (sector)
      3'd0: begin hi = 3'b100; lo = 3'b010; end
      3'd1: begin hi = 3'b100; lo = 3'b001; end
      3'd2: begin hi = 3'b010; lo = 3'b001; end
      3'd3: begin hi = 3'b010; lo = 3'b100; end
      3'd4: begin hi = 3'b001; lo = 3'b100; end
      3'd5: begin hi = 3'b001; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    pe_d = dir ? {lo & {3{pwm_on}}, hi} : {hi & {3{pwm_on}}, lo};
    if (brake)            pe_d = 6'b000111;
    if (fault_q || !en)   pe_d = 6'b000000;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      ctrl_q        <= '0;
      period_sh_q   <= PWM_W'(PERIOD_RST);
      period_act_q  <= PWM_W'(PERIOD_RST);
      duty_sh_q     <= '0;
      duty_act_q    <= '0;
      cnt_q         <= '0;
      comm_q        <= '0;
      fault_q       <= 1'b0;
      hall_s1_q     <= '0;
      hall_s2_q     <= '0;
      prev_sector_q <= 3'd7;
      pe_q          <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      period_sh_q   <= period_sh_d;
      period_act_q  <= period_act_d;
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      cnt_q         <= cnt_d;
      comm_q        <= comm_d;
      fault_q       <= fault_d;
      hall_s1_q     <= hall_values;
      hall_s2_q     <= hall_s1_q;
      prev_sector_q <= sector;
      pe_q          <= pe_d;
    end
  end

endmodule

// File: tb/tb_apb_bldc_commutator.sv
// Bench for apb_bldc_commutator: APB driver task, per-feature test tasks,
// expected read data queued at issue time and popped when pready returns.
module tb_apb_bldc_commutator;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [2:0]  hall_values;
  logic [5:0]  phase_enable;
  logic        fault_irq;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  logic [31:0] rd, e;
  logic        er, ok, lk;
  int          lat;
  int          exp_comm;

  apb_bldc_commutator #(.DATA_W(32), .ADDR_W(8), .PWM_W(10), .PERIOD_RST(1002)) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .hall_values(hall_values), .phase_enable(phase_enable), .fault_irq(fault_irq),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 pclk = ~pclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // driver: one APB transfer; lat counts cycles from psel to pready (psel cycle = 1)
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lt,
                          output logic okay, output logic leak);
    rdata = '0; err = 1'b0; lt = 0; okay = 1'b0; leak = 1'b0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge pclk); #1 penable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        rdata = prdata; err = pslverr; lt = i + 2; okay = 1'b1;
        break;
      end else if (prdata !== 32'h0) begin
        leak = 1'b1;
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0]  addrs [5];
    logic [31:0] exps  [5];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h14};
    exps  = '{32'h0, 32'h38, 32'd1002, 32'h0, 32'h0};
    preset_n = 1'b0;
    repeat (3) @(negedge pclk);
    n_tests++;
    if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0 || phase_enable !== 6'h0 ||
        fault_irq !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: pready=%b prdata=%h pslverr=%b pe=%b irq=%b st=%0d, expected all 0",
               pready, prdata, pslverr, phase_enable, fault_irq, dbg_state);
    end
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 5; i++) exp_q.push_back(exps[i]);
    for (int i = 0; i < 5; i++) begin
      apb_xfer(1'b0, addrs[i], 32'h0, rd, er, lat, ok, lk);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || rd !== e || er !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_reg[%h]: got %h err=%b ok=%b, expected %h err=0", addrs[i], rd, er, ok, e);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] p, d;
    apb_xfer(1'b1, 8'h00, 32'hFFFF_FFFA, rd, er, lat, ok, lk);
    exp_q.push_back(32'h2);
    apb_xfer(1'b0, 8'h00, 32'h0, rd, er, lat, ok, lk);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || rd !== e || er !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_mask: got %h err=%b, expected %h", rd, er, e);
    end
    apb_xfer(1'b1, 8'h00, 32'h0, rd, er, lat, ok, lk);
    for (int k = 0; k < 3; k++) begin
      p = $urandom_range(1, 1023);
      d = $urandom_range(0, 1023);
      apb_xfer(1'b1, 8'h08, p | 32'hFFFF_FC00, rd, er, lat, ok, lk);
      exp_q.push_back(p);
      apb_xfer(1'b1, 8'h0C, d, rd, er, lat, ok, lk);
      exp_q.push_back(d);
      apb_xfer(1'b0, 8'h08, 32'h0, rd, er, lat, ok, lk);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || rd !== e || er !== 1'b0) begin
        n_fail++;
        $display("FAIL period_rw: got %h err=%b, expected %h", rd, er, e);
      end
      apb_xfer(1'b0, 8'h0C, 32'h0, rd, er, lat, ok, lk);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || rd !== e || er !== 1'b0) begin
        n_fail++;
        $display("FAIL duty_rw: got %h err=%b, expected %h", rd, er, e);
      end
    end
  endtask

  task automatic test_status_read();
    hall_values = 3'b101;
    repeat (4) @(negedge pclk);
    exp_q.push_back(32'h05);
    apb_xfer(1'b0, 8'h04, 32'h0, rd, er, lat, ok, lk);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || rd !== e || er !== 1'b0) begin
      n_fail++;
      $display("FAIL status_read: got %h err=%b, expected %h err=0", rd, er, e);
    end
    n_tests++;
    if (lat !== 3 || lk !== 1'b0) begin
      n_fail++;
      $display("FAIL status_latency: lat=%0d leak=%b, expected lat=3 leak=0", lat, lk);
    end
  endtask

  task automatic test_pwm();
    int ah_cnt, bl_cnt, other, overlap;
    apb_xfer(1'b1, 8'h08, 32'd9, rd, er, lat, ok, lk);
    apb_xfer(1'b1, 8'h0C, 32'd3, rd, er, lat, ok, lk);
    repeat (2) @(negedge pclk);
    apb_xfer(1'b1, 8'h00, 32'h1, rd, er, lat, ok, lk);
    repeat (3) @(negedge pclk);
    ah_cnt = 0; bl_cnt = 0; other = 0; overlap = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge pclk);
      if (phase_enable[5]) ah_cnt++;
      if (phase_enable[1]) bl_cnt++;
      if ((phase_enable & 6'b011101) != 6'b0) other++;
      if ((phase_enable[5:3] & phase_enable[2:0]) != 3'b0) overlap++;
    end
    n_tests++;
    if (ah_cnt !== 9 || bl_cnt !== 30) begin
      n_fail++;
      $display("FAIL pwm_duty: AH on %0d/30 BL on %0d/30, expected 9/30 and 30/30", ah_cnt, bl_cnt);
    end
    n_tests++;
    if (other !== 0 || overlap !== 0) begin
      n_fail++;
      $display("FAIL pwm_other_bits: stray=%0d shoot_through=%0d, expected 0 and 0", other, overlap);
    end
    exp_q.push_back(32'h85);
    apb_xfer(1'b0, 8'h04, 32'h0, rd, er, lat, ok, lk);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || rd !== e) begin
      n_fail++;
      $display("FAIL status_running: got %h, expected %h", rd, e);
    end
  endtask

  task automatic test_duty_update();
    logic prev_ah, seen;
    int early, run;
    prev_ah = 1'b1; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge pclk);
      if (phase_enable[5] && !prev_ah) seen = 1'b1;
      prev_ah = phase_enable[5];
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL duty_sync: AH rise seen=%b, expected 1", seen);
    end
    apb_xfer(1'b1, 8'h0C, 32'd7, rd, er, lat, ok, lk);
    early = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      if (phase_enable[5]) early++;
    end
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL duty_mid_period: AH high %0d cycles before wrap, expected 0", early);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge pclk);
      if (phase_enable[5]) seen = 1'b1;
    end
    run = seen ? 1 : 0;
    for (int i = 0; i < 15 && seen; i++) begin
      @(negedge pclk);
      if (phase_enable[5]) run++;
      else seen = 1'b0;
    end
    n_tests++;
    if (run !== 7) begin
      n_fail++;
      $display("FAIL duty_after_wrap: AH run %0d cycles, expected 7", run);
    end
  endtask

  task automatic test_fault_comm();
    logic [2:0] steps [3];
    steps = '{3'b100, 3'b110, 3'b000};
    exp_comm = 0;
    for (int i = 0; i < 3; i++) begin
      hall_values = steps[i];
      if (steps[i] != 3'b000) exp_comm++;
      repeat (4) @(negedge pclk);
    end
    n_tests++;
    if (fault_irq !== 1'b1 || phase_enable !== 6'h0) begin
      n_fail++;
      $display("FAIL fault_set: irq=%b pe=%b, expected 1 and 000000", fault_irq, phase_enable);
    end
    exp_q.push_back(32'(exp_comm));
    apb_xfer(1'b0, 8'h14, 32'h0, rd, er, lat, ok, lk);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || rd !== e || er !== 1'b0) begin
      n_fail++;
      $display("FAIL comm_cnt: got %0d err=%b, expected %0d", rd, er, e);
    end
    exp_q.push_back(32'h78);
    apb_xfer(1'b0, 8'h04, 32'h0, rd, er, lat, ok, lk);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || rd !== e) begin
      n_fail++;
      $display("FAIL status_fault: got %h, expected %h", rd, e);
    end
    apb_xfer(1'b1, 8'h10, 32'h1, rd, er, lat, ok, lk);
    @(negedge pclk);
    n_tests++;
    if (fault_irq !== 1'b1 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_set_wins: irq=%b err=%b, expected 1 and 0", fault_irq, er);
    end
    hall_values = 3'b101;
    repeat (4) @(negedge pclk);
    n_tests++;
    if (fault_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: irq=%b, expected 1", fault_irq);
    end
    apb_xfer(1'b1, 8'h10, 32'h1, rd, er, lat, ok, lk);
    @(negedge pclk);
    n_tests++;
    if (fault_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear: irq=%b, expected 0", fault_irq);
    end
  endtask

  task automatic test_errors();
    logic       wrs   [5];
    logic [7:0] addrs [5];
    wrs   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    addrs = '{8'h04, 8'h10, 8'h20, 8'h14, 8'h22};
    for (int i = 0; i < 5; i++) begin
      apb_xfer(wrs[i], addrs[i], 32'hFFFF_FFFF, rd, er, lat, ok, lk);
      n_tests++;
      if (!ok || er !== 1'b1 || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL slverr[%h wr=%b]: err=%b prdata=%h ok=%b, expected err=1 prdata=0",
                 addrs[i], wrs[i], er, rd, ok);
      end
    end
    exp_q.push_back(32'h1);
    exp_q.push_back(32'(exp_comm));
    apb_xfer(1'b0, 8'h00, 32'h0, rd, er, lat, ok, lk);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL err_ctrl_unchanged: got %h, expected %h", rd, e);
    end
    apb_xfer(1'b0, 8'h14, 32'h0, rd, er, lat, ok, lk);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL err_comm_unchanged: got %h, expected %h", rd, e);
    end
  endtask

  task automatic test_brake_reset();
    logic [7:0]  addrs [4];
    logic [31:0] exps  [4];
    addrs = '{8'h00, 8'h08, 8'h0C, 8'h14};
    exps  = '{32'h0, 32'd1002, 32'h0, 32'h0};
    apb_xfer(1'b1, 8'h00, 32'h7, rd, er, lat, ok, lk);
    repeat (3) @(negedge pclk);
    n_tests++;
    if (phase_enable !== 6'b000111) begin
      n_fail++;
      $display("FAIL brake: pe=%b, expected 000111", phase_enable);
    end
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h1;
    @(posedge pclk); #1 penable = 1'b1;
    #7 preset_n = 1'b0;
    #1;
    n_tests++;
    if (phase_enable !== 6'h0 || pready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pe=%b pready=%b, expected 000000 and 0", phase_enable, pready);
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 4; i++) exp_q.push_back(exps[i]);
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, addrs[i], 32'h0, rd, er, lat, ok, lk);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || rd !== e || er !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset[%h]: got %h err=%b, expected %h", addrs[i], rd, er, e);
      end
    end
    n_tests++;
    if (phase_enable !== 6'h0 || fault_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: pe=%b irq=%b, expected 0 and 0", phase_enable, fault_irq);
    end
  endtask

  initial begin
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; hall_values = 3'b000;
    test_reset();
    test_regs();
    test_status_read();
    test_pwm();
    test_duty_update();
    test_fault_comm();
    test_errors();
    test_brake_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
